// File: rtl/shift_seq_counter.sv
// Run-time selectable ring / Johnson / Fibonacci-LFSR shift counter with load, enable and wrap pulse.
// Optional lock-up recovery is compiled in with `define SHIFT_SEQ_LOCKUP_RECOVER_EN.
module shift_seq_counter #(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = 4'b1001,
  parameter logic [WIDTH-1:0] TAPS      = 4'b0011
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [1:0]       mode,
  input  logic             dir,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_n,
  output logic             wrap,
  output logic             lockup
);

  localparam logic [1:0] MODE_RING = 2'b00;
  localparam logic [1:0] MODE_JOHN = 2'b01;
  localparam logic [1:0] MODE_LFSR = 2'b10;
  localparam logic [1:0] MODE_HOLD = 2'b11;

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_start;
  logic             r_wrap;
  logic             w_fb;
  logic [WIDTH-1:0] w_shift;
  logic [WIDTH-1:0] w_next;

  always_comb begin
    w_fb = 1'b0;
    case (mode)
      MODE_RING: w_fb = dir ? r_q[WIDTH-1] : r_q[0];
      MODE_JOHN: w_fb = dir ? ~r_q[WIDTH-1] : ~r_q[0];
      MODE_LFSR: w_fb = ^(r_q & TAPS);
      default:   w_fb = 1'b0;
    endcase
  end

  // LFSR always shifts toward bit 0; dir only steers ring and Johnson.
  always_comb begin
    w_shift = r_q;
    if (mode == MODE_HOLD)
      w_shift = r_q;
    else if (dir && (mode != MODE_LFSR))
      w_shift = {r_q[WIDTH-2:0], w_fb};
    else
      w_shift = {w_fb, r_q[WIDTH-1:1]};
  end

`ifdef SHIFT_SEQ_LOCKUP_RECOVER_EN
  logic w_lock;
  logic r_lockup;

  always_comb begin
    w_lock = ((mode == MODE_LFSR) && (r_q == '0)) ||
             ((mode == MODE_RING) && ((r_q == '0) || (r_q == '1)));
    w_next = w_lock ? r_start : w_shift;
  end

  always_ff @(posedge clk) begin
    if (rst)
      r_lockup <= 1'b0;
    else if (load)
      r_lockup <= 1'b0;
    else
      r_lockup <= en && w_lock;
  end

  assign lockup = r_lockup;
`else
  always_comb w_next = w_shift;
  assign lockup = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q     <= RESET_VAL;
      r_start <= RESET_VAL;
      r_wrap  <= 1'b0;
    end else if (load) begin
      r_q     <= load_val;
      r_start <= load_val;
      r_wrap  <= 1'b0;
    end else if (en && (mode != MODE_HOLD)) begin
      r_q    <= w_next;
      r_wrap <= (w_next == r_start);
    end else begin
      r_wrap <= 1'b0;
    end
  end

  assign q    = r_q;
  assign q_n  = ~r_q;
  assign wrap = r_wrap;

endmodule
